// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// CTRL bit positions and the timer state encoding.
package dmem_mmio_responder_pkg;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_CTRL   = 8'h04;
  localparam logic [7:0] OFF_LOAD   = 8'h08;
  localparam logic [7:0] OFF_COUNT  = 8'h0C;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_CYCLES = 8'h14;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } timer_state_t;

  // Word-aligned MMIO offset; the two byte-select bits never matter.
  function automatic logic [7:0] word_offset(input logic [7:2] byte_off);
    return {byte_off, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_timer.sv
// Down-counting timer: owns CTRL, LOAD, COUNT and STATUS plus the IDLE/RUN/DONE
// sequencer. Register writes arrive as strobe + word offset + data.
module dmem_timer
  import dmem_mmio_responder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  off,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  logic [2:0]   ctrl_reg;
  logic [31:0]  load_reg;
  logic [31:0]  count_reg;
  logic         expired_reg;
  timer_state_t state_reg;

  logic ctrl_wr;
  logic load_wr;
  logic status_wr;
  logic start;
  logic stop;

  assign ctrl_wr   = wr_en && (off == OFF_CTRL);
  assign load_wr   = wr_en && (off == OFF_LOAD);
  assign status_wr = wr_en && (off == OFF_STATUS);
  assign start     = ctrl_wr && wr_data[CTRL_EN] && !ctrl_reg[CTRL_EN];
  assign stop      = ctrl_wr && !wr_data[CTRL_EN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg    <= '0;
      load_reg    <= '0;
      count_reg   <= '0;
      expired_reg <= 1'b0;
      state_reg   <= T_IDLE;
    end else begin
      if (ctrl_wr)
        ctrl_reg <= wr_data[2:0];
      if (load_wr)
        load_reg <= wr_data;
      if (status_wr && wr_data[0])
        expired_reg <= 1'b0;

      // Start/stop writes pre-empt the counting step; the expiry set below
      // comes later so it overrides a simultaneous W1C clear.
      if (start) begin
        count_reg <= load_reg;
        state_reg <= T_RUN;
      end else if (stop) begin
        state_reg <= T_IDLE;
      end else begin
        case (state_reg)
          T_RUN: begin
            if (count_reg != 32'd0) begin
              count_reg <= count_reg - 32'd1;
            end else begin
              expired_reg <= 1'b1;
              if (ctrl_reg[CTRL_AUTO])
                count_reg <= load_reg;
              else
                state_reg <= T_DONE;
            end
          end
          T_IDLE, T_DONE: state_reg <= state_reg;
          default:        state_reg <= T_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_CTRL:   rd_data = {29'd0, ctrl_reg};
      OFF_LOAD:   rd_data = load_reg;
      OFF_COUNT:  rd_data = count_reg;
      OFF_STATUS: rd_data = {31'd0, expired_reg};
      default:    rd_data = '0;
    endcase
  end

  assign irq = expired_reg & ctrl_reg[CTRL_IRQEN];

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: word RAM with zero-latency reads plus an MMIO
// window holding LED, the timer block and a free-running cycle counter.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWrite,
  input  logic [31:0]           aluout,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [15:0]           led,
  output logic                  timer_irq,
  input  logic [DEPTH_LOG2-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                  mmio_sel;
  logic [7:0]            off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  ram_we;
  logic [31:0]           ram_rd;
  logic [31:0]           mem [DEPTH];

  logic [15:0] led_reg;
  logic [31:0] cycles_reg;
  logic [31:0] timer_rd;
  logic [31:0] mmio_rd;
  logic        unused_byte_sel;

  assign mmio_sel        = (aluout[31:8] == MMIO_BASE[31:8]);
  assign off             = word_offset(aluout[7:2]);
  assign ram_idx         = aluout[DEPTH_LOG2+1:2];
  assign ram_we          = MemWrite && !mmio_sel;
  assign unused_byte_sel = ^aluout[1:0];

  // RAM is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we)
      mem[ram_idx] <= writedata;
  end

  assign ram_rd   = mem[ram_idx];
  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg    <= '0;
      cycles_reg <= '0;
    end else begin
      if (MemWrite && mmio_sel && (off == OFF_LED))
        led_reg <= writedata[15:0];
      cycles_reg <= cycles_reg + 32'd1;
    end
  end

  dmem_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (MemWrite && mmio_sel),
    .off     (off),
    .wr_data (writedata),
    .rd_data (timer_rd),
    .irq     (timer_irq)
  );

  // The timer returns zero outside its own offsets, so it is the fallback.
  always_comb begin
    mmio_rd = timer_rd;
    case (off)
      OFF_LED:    mmio_rd = {16'd0, led_reg};
      OFF_CYCLES: mmio_rd = cycles_reg;
      default:    mmio_rd = timer_rd;
    endcase
  end

  assign readdata = mmio_sel ? mmio_rd : ram_rd;
  assign led      = led_reg;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: vector table, hand-built timer/reset/wrap
// sequences and a randomized run against a behavioural model.
module tb_dmem_mmio_responder;

  localparam int          DL      = 10;
  localparam logic [31:0] BASE    = 32'h0000_7F00;
  localparam logic [23:0] BASE_HI = 24'h00007F;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemWrite;
  logic [31:0]   aluout;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [15:0]   led;
  logic          timer_irq;
  logic [DL-1:0] dbg_addr;
  logic [31:0]   dbg_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_mmio_responder #(.DEPTH_LOG2(DL), .MMIO_BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .led       (led),
    .timer_irq (timer_irq),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: timer reduced to "counting or not" plus plain values.
  logic [31:0] m_ram [int];
  logic [15:0] m_led;
  logic        m_en, m_auto, m_irqen, m_expired, m_counting;
  logic [31:0] m_load, m_count, m_cycles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite  = we;
    aluout    = a;
    writedata = d;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    MemWrite = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic txc(input string name, input logic we, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp);
    drive(we, a, d);
    check(name, readdata, exp);
    $display("tx %s we=%0b addr=%h wdata=%h rd=%h", name, we, a, d, readdata);
    tick();
  endtask

  function automatic void add(input logic we, input logic [31:0] a, input logic [31:0] d,
                              input logic chk, input logic [31:0] exp_rd,
                              input logic [15:0] exp_led, input logic exp_irq);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.chk = chk;
    v.exp_rd = exp_rd; v.exp_led = exp_led; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endfunction

  task automatic m_reset();
    m_led = '0; m_en = 0; m_auto = 0; m_irqen = 0; m_expired = 0; m_counting = 0;
    m_load = '0; m_count = '0; m_cycles = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a, output logic known);
    logic [7:0] o;
    int idx;
    o = {a[7:2], 2'b00};
    known = 1'b1;
    if (a[31:8] == BASE_HI) begin
      case (o)
        8'h00:   return {16'd0, m_led};
        8'h04:   return {29'd0, m_irqen, m_auto, m_en};
        8'h08:   return m_load;
        8'h0C:   return m_count;
        8'h10:   return {31'd0, m_expired};
        8'h14:   return m_cycles;
        default: return 32'd0;
      endcase
    end
    idx = int'(a[11:2]);
    known = m_ram.exists(idx);
    return known ? m_ram[idx] : 32'd0;
  endfunction

  task automatic m_step(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic       mm;
    logic [7:0] o;
    logic       nxt_exp;
    mm = (a[31:8] == BASE_HI);
    o  = {a[7:2], 2'b00};
    if (we && !mm) m_ram[int'(a[11:2])] = d;
    nxt_exp = m_expired;
    if (we && mm && o == 8'h10 && d[0]) nxt_exp = 1'b0;
    if (we && mm && o == 8'h04 && d[0] && !m_en) begin
      m_count = m_load;
      m_counting = 1'b1;
    end else if (we && mm && o == 8'h04 && !d[0]) begin
      m_counting = 1'b0;
    end else if (m_counting) begin
      if (m_count != 0) m_count = m_count - 1;
      else begin
        nxt_exp = 1'b1;
        if (m_auto) m_count = m_load;
        else m_counting = 1'b0;
      end
    end
    m_expired = nxt_exp;
    if (we && mm && o == 8'h04) {m_irqen, m_auto, m_en} = d[2:0];
    if (we && mm && o == 8'h08) m_load = d;
    if (we && mm && o == 8'h00) m_led = d[15:0];
    m_cycles = m_cycles + 1;
  endtask

  task automatic rtx(input int n, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic        known;
    logic [31:0] exp;
    int          di;
    di = 100 + int'($urandom_range(0, 15));
    dbg_addr = di[DL-1:0];
    drive(we, a, d);
    exp = m_read(a, known);
    if (known) check("rnd_rd", readdata, exp);
    check("rnd_led", {16'd0, led}, {16'd0, m_led});
    check("rnd_irq", {31'd0, timer_irq}, {31'd0, m_expired & m_irqen});
    if (m_ram.exists(di)) check("rnd_dbg", dbg_data, m_ram[di]);
    $display("rnd %0d we=%0b addr=%h wdata=%h rd=%h", n, we, a, d, readdata);
    m_step(we, a, d);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic        we;
    int          k;

    rst = 1'b1; MemWrite = 1'b0; aluout = '0; writedata = '0; dbg_addr = '0;
    tick();
    rst = 1'b0;

    // RAM, decode/alias, LED, then a one-shot timer run
    add(1, 32'h40,      32'h1111_1111, 0, 32'h0,          16'h0,    0);
    add(1, 32'h40,      32'hDEAD_BEEF, 1, 32'h1111_1111,  16'h0,    0);
    add(0, 32'h40,      32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0);
    add(0, 32'h43,      32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0);
    add(0, 32'h1040,    32'h0,         1, 32'hDEAD_BEEF,  16'h0,    0);
    add(1, 32'hF00,     32'hCAFE_F00D, 0, 32'h0,          16'h0,    0);
    add(1, BASE+32'h00, 32'h0001_1234, 1, 32'h0,          16'h0,    0);
    add(0, BASE+32'h00, 32'h0,         1, 32'h1234,       16'h1234, 0);
    add(0, 32'h1F00,    32'h0,         1, 32'hCAFE_F00D,  16'h1234, 0);
    add(0, BASE+32'h18, 32'h0,         1, 32'h0,          16'h1234, 0);
    add(0, BASE+32'h1C, 32'h0,         1, 32'h0,          16'h1234, 0);
    add(1, BASE+32'h08, 32'd3,         1, 32'h0,          16'h1234, 0);
    add(1, BASE+32'h04, 32'hFFFF_FFF5, 1, 32'h0,          16'h1234, 0);
    add(0, BASE+32'h0C, 32'h0,         1, 32'd3,          16'h1234, 0);
    add(0, BASE+32'h0C, 32'h0,         1, 32'd2,          16'h1234, 0);
    add(0, BASE+32'h0C, 32'h0,         1, 32'd1,          16'h1234, 0);
    add(0, BASE+32'h0C, 32'h0,         1, 32'd0,          16'h1234, 0);
    add(0, BASE+32'h10, 32'h0,         1, 32'd1,          16'h1234, 1);
    add(0, BASE+32'h0C, 32'h0,         1, 32'd0,          16'h1234, 1);
    add(1, BASE+32'h10, 32'h0,         1, 32'd1,          16'h1234, 1);
    add(1, BASE+32'h10, 32'h2,         1, 32'd1,          16'h1234, 1);
    add(1, BASE+32'h10, 32'h1,         1, 32'd1,          16'h1234, 1);
    add(0, BASE+32'h10, 32'h0,         1, 32'd0,          16'h1234, 0);
    add(0, BASE+32'h04, 32'h0,         1, 32'd5,          16'h1234, 0);
    add(1, BASE+32'h0C, 32'h55,        1, 32'd0,          16'h1234, 0);
    add(0, BASE+32'h0C, 32'h0,         1, 32'd0,          16'h1234, 0);
    add(0, BASE+32'h08, 32'h0,         1, 32'd3,          16'h1234, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_led", i), {16'd0, led}, {16'd0, vecs[i].exp_led});
      check($sformatf("vec%0d_irq", i), {31'd0, timer_irq}, {31'd0, vecs[i].exp_irq});
      $display("vec %0d we=%0b addr=%h wdata=%h rd=%h led=%h irq=%0b",
               i, vecs[i].we, vecs[i].addr, vecs[i].wdata, readdata, led, timer_irq);
      tick();
    end

    drive(0, 32'h0, 32'h0);
    dbg_addr = 10'd16;     #1; check("dbg_16", dbg_data, 32'hDEAD_BEEF);
    dbg_addr = 10'h3C0;    #1; check("dbg_3c0", dbg_data, 32'hCAFE_F00D);

    // Autoreload: LOAD=2 gives a 3-cycle period, then LOAD=5 gives 6
    do_reset();
    txc("ar_load",    1, BASE+32'h08, 32'd2, 32'd0);
    txc("ar_ctrl",    1, BASE+32'h04, 32'd3, 32'd0);
    txc("ar_c2",      0, BASE+32'h0C, 32'd0, 32'd2);
    txc("ar_c1",      0, BASE+32'h0C, 32'd0, 32'd1);
    txc("ar_c0",      0, BASE+32'h0C, 32'd0, 32'd0);
    txc("ar_ld5",     1, BASE+32'h08, 32'd5, 32'd2);
    txc("ar_w1c",     1, BASE+32'h10, 32'd1, 32'd1);
    txc("ar_c0b",     0, BASE+32'h0C, 32'd0, 32'd0);
    for (int c = 5; c >= 1; c--)
      txc($sformatf("ar_p6_%0d", c), 0, BASE+32'h0C, 32'd0, 32'(c));
    txc("ar_w1c_exp", 1, BASE+32'h10, 32'd1, 32'd1);
    txc("ar_reload",  0, BASE+32'h0C, 32'd0, 32'd5);
    drive(0, BASE+32'h10, 32'd0);
    check("ar_noirq", {31'd0, timer_irq}, 32'd0);
    txc("ar_set_wins", 0, BASE+32'h10, 32'd0, 32'd1);
    txc("ar_w1c2",    1, BASE+32'h10, 32'd1, 32'd1);
    txc("ar_cleared", 0, BASE+32'h10, 32'd0, 32'd0);

    // Asynchronous reset while counting
    do_reset();
    txc("rs_led",    1, BASE+32'h00, 32'h0000_BEEF, 32'd0);
    txc("rs_ld0",    1, BASE+32'h08, 32'd0, 32'd0);
    txc("rs_go",     1, BASE+32'h04, 32'd7, 32'd0);
    txc("rs_st0",    0, BASE+32'h10, 32'd0, 32'd0);
    drive(0, BASE+32'h10, 32'd0);
    check("rs_irq_on", {31'd0, timer_irq}, 32'd1);
    txc("rs_st1",    0, BASE+32'h10, 32'd0, 32'd1);
    txc("rs_stop",   1, BASE+32'h04, 32'd4, 32'd7);
    txc("rs_ld9",    1, BASE+32'h08, 32'd9, 32'd0);
    txc("rs_go2",    1, BASE+32'h04, 32'd5, 32'd4);
    txc("rs_c9",     0, BASE+32'h0C, 32'd0, 32'd9);
    txc("rs_c8",     0, BASE+32'h0C, 32'd0, 32'd8);
    drive(0, BASE+32'h0C, 32'd0);
    check("rs_c7",     readdata, 32'd7);
    check("rs_irq_pre", {31'd0, timer_irq}, 32'd1);
    check("rs_led_pre", {16'd0, led}, 32'h0000_BEEF);
    rst = 1'b1;
    #1;
    check("rs_count0", readdata, 32'd0);
    check("rs_led0",   {16'd0, led}, 32'd0);
    check("rs_irq0",   {31'd0, timer_irq}, 32'd0);
    drive(0, BASE+32'h14, 32'd0); check("rs_cycles0", readdata, 32'd0);
    drive(0, BASE+32'h08, 32'd0); check("rs_load0",   readdata, 32'd0);
    drive(0, BASE+32'h04, 32'd0); check("rs_ctrl0",   readdata, 32'd0);
    tick();
    rst = 1'b0;
    dbg_addr = 10'd16; #1;
    check("rs_ram_dbg", dbg_data, 32'hDEAD_BEEF);
    txc("rs_ram_rd", 0, 32'h40, 32'd0, 32'hDEAD_BEEF);

    // CYCLES counting and wrap
    do_reset();
    txc("cy_0", 0, BASE+32'h14, 32'd0, 32'd0);
    txc("cy_1", 0, BASE+32'h14, 32'd0, 32'd1);
    txc("cy_2", 0, BASE+32'h14, 32'd0, 32'd2);
    dut.cycles_reg = 32'hFFFF_FFFE;
    txc("cy_fffe", 0, BASE+32'h14, 32'd0, 32'hFFFF_FFFE);
    txc("cy_ffff", 0, BASE+32'h14, 32'd0, 32'hFFFF_FFFF);
    txc("cy_wrap", 0, BASE+32'h14, 32'd0, 32'd0);
    txc("cy_after", 0, BASE+32'h14, 32'd0, 32'd1);

    // Randomized traffic against the model
    do_reset();
    m_reset();
    for (int i = 0; i < 16; i++)
      rtx(i, 1'b1, 32'((100 + i) << 2), $urandom());
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        we = 1'($urandom_range(0, 1));
        a  = ($urandom() & 32'hFFFF_F000) | 32'((100 + $urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        d  = $urandom();
      end else begin
        k  = int'($urandom_range(0, 7));
        we = 1'($urandom_range(0, 1));
        a  = BASE | 32'(k * 4) | 32'($urandom_range(0, 3));
        d  = (k == 2) ? 32'($urandom_range(0, 6)) : $urandom();
        if (k == 1 && $urandom_range(0, 2) != 0) we = 1'b0;
      end
      rtx(16 + n, we, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Memory-side responder for the pipelined CPU's data-memory port. It answers the MEM stage's MemWrite/aluout/writedata strobes and returns readdata in the same cycle. It contains a word-addressed data RAM and a small MMIO window holding an LED register, a programmable down-counting timer with interrupt flag, and a free-running cycle counter. It sits between the CPU top and the board level and replaces a bare RAM on the data side.

Parameters:
DEPTH_LOG2, 10, RAM holds 2^DEPTH_LOG2 32-bit words
MMIO_BASE, 32'h0000_7F00, base of the 256-byte MMIO window (low 8 bits must be 0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
MemWrite  input  1  store strobe from CPU MEM stage
aluout  input  32  byte address from CPU MEM stage
writedata  input  32  store data from CPU MEM stage
readdata  output  32  load data to CPU, combinational from current aluout
led  output  16  LED register contents
timer_irq  output  1  timer interrupt, level
dbg_addr  input  DEPTH_LOG2  RAM word index for debug read
dbg_data  output  32  RAM word at dbg_addr, combinational

Behaviour:
- Decode: aluout[31:8]==MMIO_BASE[31:8] selects MMIO, else RAM. aluout[1:0] ignored (word access only). RAM index = aluout[DEPTH_LOG2+1:2]; upper bits alias.
- RAM: write on rising clk when MemWrite & RAM selected. Read is asynchronous, zero latency. Read-during-write to the same word returns the old data in that cycle and the new data from the next cycle. RAM is not cleared by rst.
- MMIO map (offset = aluout[7:0]); any unmapped offset reads 0 and ignores writes:
  - 0x00 LED: RW, bits[15:0]; upper bits read 0.
  - 0x04 CTRL: RW. bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; other bits read 0.
  - 0x08 LOAD: RW, 32-bit.
  - 0x0C COUNT: RO, current count. Writes are ignored.
  - 0x10 STATUS: bit0 EXPIRED. Write 1 clears it; write 0 has no effect.
  - 0x14 CYCLES: RO, 32-bit. Increments every cycle and wraps from FFFF_FFFF to 0.
- MMIO writes take effect on the rising clk where MemWrite is high. readdata shows the pre-write value in that cycle.
- Timer FSM, states IDLE, RUN, DONE:
  - Leaving reset: IDLE.
  - Any state, on a CTRL write with EN=1 where the stored EN was 0: COUNT<=LOAD and go to RUN.
  - Any state, on a CTRL write with EN=0: go to IDLE; COUNT holds.
  - CTRL write with EN=1 while stored EN is already 1: only the AUTORELOAD and IRQ_EN bits update; no restart.
  - RUN, COUNT!=0: COUNT<=COUNT-1.
  - RUN, COUNT==0: EXPIRED<=1. If AUTORELOAD, COUNT<=LOAD and stay in RUN; else go to DONE with COUNT held at 0.
  - DONE: holds until a CTRL write.
  - Period = LOAD+1 cycles. LOAD=0 with AUTORELOAD expires every cycle.
  - A LOAD write during RUN affects only the next reload.
- EXPIRED set and a W1C clear in the same cycle: set wins.
- timer_irq = EXPIRED & IRQ_EN, combinational from registers, no glitch path from aluout.
- Reset values:
  - led=0, CTRL=0, LOAD=0, COUNT=0, EXPIRED=0, CYCLES=0, state IDLE, timer_irq=0.
  - readdata for any MMIO address reads 0 except CYCLES.
- Reset asserted mid-count: all timer/MMIO state clears immediately (async). RAM contents are kept.

Decomposition:
- Shared package holds:
  - MMIO offset constants (OFF_LED, OFF_CTRL, OFF_LOAD, OFF_COUNT, OFF_STATUS, OFF_CYCLES)
  - CTRL bit indices (CTRL_EN, CTRL_AUTO, CTRL_IRQEN)
  - timer state encoding (T_IDLE=2'd0, T_RUN=2'd1, T_DONE=2'd2)
- One sub-module, dmem_timer, owns CTRL/LOAD/COUNT/STATUS and the FSM. Its interface is a write strobe plus offset plus data in, and register read-back out.
- RAM, decode, LED and CYCLES stay in the top.

Test Plan:
- RAM store/load: write 0xDEADBEEF to 0x40; same cycle readdata=old value, next cycle readdata=0xDEADBEEF and dbg_addr=16 gives dbg_data=0xDEADBEEF.
- Alias/decode: write 0x1234 to MMIO_BASE+0x00 -> led=0x1234 next cycle, RAM word 0x7F00>>2 unchanged. Read MMIO_BASE+0x18 -> 0.
- One-shot timer: LOAD=3, CTRL=0b101 -> COUNT 3,2,1,0 over 4 cycles. EXPIRED=1 and timer_irq=1 at the 5th edge, state DONE, COUNT stays 0. Write STATUS=1 -> timer_irq=0.
- Autoreload: LOAD=2, CTRL=0b011 -> EXPIRED sets every 3 cycles. Write LOAD=5 mid-run -> next period 6 cycles. W1C on the same cycle as expiry leaves EXPIRED=1.
- Reset mid-operation: timer in RUN with COUNT=7, assert rst between edges -> COUNT=0, led=0, timer_irq=0 immediately, CYCLES=0. A previously written RAM word still reads back unchanged.
- CYCLES wrap: force CYCLES near FFFF_FFFE via a long run or a hierarchical deposit -> reads FFFF_FFFF then 0.
